// File: rtl/chroni_pkg.sv
// Shared Chroni definitions: default bus widths, VRAM port IDs and the
// VRAM responder FSM state encoding.
package chroni_pkg;

  localparam int CHRONI_ADDR_W = 13;
  localparam int CHRONI_DATA_W = 8;

  localparam bit PORT_VID = 1'b0;
  localparam bit PORT_CPU = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACK,
    ST_GAP
  } vram_state_e;

endpackage

// File: rtl/chroni_vram_port_if.sv
// Video fetch, CPU and memory-macro signals of the VRAM responder; slave is the
// responder side, master the requester/memory side.
interface chroni_vram_port_if
  import chroni_pkg::*;
#(
  parameter int ADDR_W = CHRONI_ADDR_W,
  parameter int DATA_W = CHRONI_DATA_W
);
  logic              vid_rd_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_rd_ack;
  logic [DATA_W-1:0] vid_data;

  logic              cpu_rd_req;
  logic              cpu_wr_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rd_data;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd_data;

  modport slave (
    input  vid_rd_req, vid_addr, cpu_rd_req, cpu_wr_req, cpu_addr, cpu_wr_data, mem_rd_data,
    output vid_rd_ack, vid_data, cpu_ack, cpu_rd_data, mem_addr, mem_wr_data, mem_we
  );

  modport master (
    output vid_rd_req, vid_addr, cpu_rd_req, cpu_wr_req, cpu_addr, cpu_wr_data, mem_rd_data,
    input  vid_rd_ack, vid_data, cpu_ack, cpu_rd_data, mem_addr, mem_wr_data, mem_we
  );
endinterface

// File: rtl/chroni_vram_arbiter.sv
// Video-priority grant with a burst counter that forces a CPU grant after
// VID_BURST_MAX consecutive video grants; grant is combinational, valid only when idle.
module chroni_vram_arbiter
  import chroni_pkg::*;
#(
  parameter int VID_BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       idle,
  output logic       grant,
  output logic       port
);

  logic [2:0] burst_cnt;
  logic       cpu_turn;

  always_comb begin
    cpu_turn = req[PORT_CPU] && (!req[PORT_VID] || burst_cnt == 3'(VID_BURST_MAX));
    grant    = idle && (req[PORT_VID] || req[PORT_CPU]);
    port     = cpu_turn ? PORT_CPU : PORT_VID;
  end

  // Counts only video grants that overtook a waiting CPU request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (!req[PORT_CPU]) begin
      burst_cnt <= '0;
    end else if (grant && port == PORT_CPU) begin
      burst_cnt <= '0;
    end else if (grant) begin
      burst_cnt <= burst_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/chroni_vram_port.sv
// Single-port VRAM responder for Chroni video fetch and CPU access; reads ack at
// cycle 2+MEM_LATENCY, writes at cycle 2, requests held until ack plus one GAP cycle.
module chroni_vram_port
  import chroni_pkg::*;
#(
  parameter int ADDR_W        = CHRONI_ADDR_W,
  parameter int DATA_W        = CHRONI_DATA_W,
  parameter int MEM_LATENCY   = 1,
  parameter int VID_BURST_MAX = 4
) (
  input logic               sys_clk,
  input logic               reset_n,
  chroni_vram_port_if.slave bus
);

  vram_state_e       state, state_nxt;
  logic [1:0]        req;
  logic              grant, gnt_port;
  logic [1:0]        lat_cnt;
  logic              lat_done;
  logic              port_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, vid_data_q, cpu_data_q;

  always_comb begin
    req           = '0;
    req[PORT_VID] = bus.vid_rd_req;
    req[PORT_CPU] = bus.cpu_rd_req | bus.cpu_wr_req;
  end

  chroni_vram_arbiter #(.VID_BURST_MAX(VID_BURST_MAX)) u_arb (
    .clk   (sys_clk),
    .rst_n (reset_n),
    .req   (req),
    .idle  (state == ST_IDLE),
    .grant (grant),
    .port  (gnt_port)
  );

  assign lat_done = (lat_cnt == 2'(MEM_LATENCY - 1));

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (grant) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = wr_q ? ST_ACK : ST_WAIT;
      ST_WAIT:  if (lat_done) state_nxt = ST_ACK;
      ST_ACK:   state_nxt = ST_GAP;
      ST_GAP:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt    <= '0;
      port_q     <= PORT_VID;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      vid_data_q <= '0;
      cpu_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            port_q  <= gnt_port;
            addr_q  <= (gnt_port == PORT_CPU) ? bus.cpu_addr : bus.vid_addr;
            // Both CPU strobes high resolves to a write.
            wr_q    <= (gnt_port == PORT_CPU) && bus.cpu_wr_req;
            wdata_q <= bus.cpu_wr_data;
          end
        end
        ST_ISSUE: lat_cnt <= '0;
        ST_WAIT: begin
          lat_cnt <= lat_cnt + 2'd1;
          if (lat_done) begin
            if (port_q == PORT_VID) vid_data_q <= bus.mem_rd_data;
            else                    cpu_data_q <= bus.mem_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_data = wdata_q;
  assign bus.mem_we      = (state == ST_ISSUE) && wr_q;
  assign bus.vid_rd_ack  = (state == ST_ACK) && (port_q == PORT_VID);
  assign bus.cpu_ack     = (state == ST_ACK) && (port_q == PORT_CPU);
  assign bus.vid_data    = vid_data_q;
  assign bus.cpu_rd_data = cpu_data_q;

endmodule

// File: tb/tb_chroni_vram_port.sv
// Directed bench for chroni_vram_port: instance A (latency 1) and instance B
// (latency 3), each backed by a behavioural synchronous memory.
module tb_chroni_vram_port;

  logic sys_clk = 1'b0;
  logic reset_n;
  bit   sel_b;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  chroni_vram_port_if #(.ADDR_W(13), .DATA_W(8)) a_if ();
  chroni_vram_port_if #(.ADDR_W(13), .DATA_W(8)) b_if ();

  chroni_vram_port #(.ADDR_W(13), .DATA_W(8), .MEM_LATENCY(1), .VID_BURST_MAX(4)) u_dut_a (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .bus     (a_if.slave)
  );

  chroni_vram_port #(.ADDR_W(13), .DATA_W(8), .MEM_LATENCY(3), .VID_BURST_MAX(4)) u_dut_b (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .bus     (b_if.slave)
  );

  logic [7:0] mem_a [0:8191];
  logic [7:0] mem_b [0:8191];
  logic [7:0] pipe_a [3];
  logic [7:0] pipe_b [3];

  always @(posedge sys_clk) begin
    if (!reset_n) begin
      mem_a[13'h401] <= 8'h41;
      mem_b[13'h123] <= 8'h77;
      mem_b[13'h055] <= 8'h9E;
    end else begin
      if (a_if.mem_we) mem_a[a_if.mem_addr] <= a_if.mem_wr_data;
      if (b_if.mem_we) mem_b[b_if.mem_addr] <= b_if.mem_wr_data;
    end
    pipe_a[0] <= mem_a[a_if.mem_addr];
    pipe_a[1] <= pipe_a[0];
    pipe_a[2] <= pipe_a[1];
    pipe_b[0] <= mem_b[b_if.mem_addr];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign a_if.mem_rd_data = pipe_a[0];
  assign b_if.mem_rd_data = pipe_b[2];

  wire       obs_vack  = sel_b ? b_if.vid_rd_ack  : a_if.vid_rd_ack;
  wire       obs_cack  = sel_b ? b_if.cpu_ack     : a_if.cpu_ack;
  wire       obs_we    = sel_b ? b_if.mem_we      : a_if.mem_we;
  wire [7:0] obs_vdata = sel_b ? b_if.vid_data    : a_if.vid_data;
  wire [7:0] obs_cdata = sel_b ? b_if.cpu_rd_data : a_if.cpu_rd_data;
  wire [12:0] obs_addr = sel_b ? b_if.mem_addr    : a_if.mem_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit vr, input logic [12:0] va, input bit cr, input bit cw,
                       input logic [12:0] ca, input logic [7:0] cd);
    if (sel_b) begin
      b_if.vid_rd_req = vr; b_if.vid_addr = va;
      b_if.cpu_rd_req = cr; b_if.cpu_wr_req = cw; b_if.cpu_addr = ca; b_if.cpu_wr_data = cd;
    end else begin
      a_if.vid_rd_req = vr; a_if.vid_addr = va;
      a_if.cpu_rd_req = cr; a_if.cpu_wr_req = cw; a_if.cpu_addr = ca; a_if.cpu_wr_data = cd;
    end
  endtask

  // One request, held until the cycle after its ack; cycle 0 is the sampling cycle.
  task automatic access(input bit cpu, input bit rd, input bit wr, input logic [12:0] a,
                        input logic [7:0] wd, output int ack_at, output int acks, output int we_cnt);
    ack_at = -1; acks = 0; we_cnt = 0;
    @(negedge sys_clk);
    if (cpu) drive(1'b0, 13'h0, rd, wr, a, wd);
    else     drive(1'b1, a, 1'b0, 1'b0, 13'h0, 8'h0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge sys_clk);
      if (c == ack_at + 1) drive(1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
      if (obs_we) we_cnt++;
      if (cpu ? obs_cack : obs_vack) begin
        acks++;
        if (ack_at < 0) ack_at = c;
      end
    end
    drive(1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
  endtask

  initial begin
    int ack_at, acks, we_cnt, n_ev, cdrop;
    int ev [6];
    int ev_t [6];

    reset_n = 1'b0;
    sel_b = 1'b1; drive(1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
    sel_b = 1'b0; drive(1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
    repeat (2) @(negedge sys_clk);
    chk("rst_vid_ack", obs_vack, 0);
    chk("rst_cpu_ack", obs_cack, 0);
    chk("rst_mem_we", obs_we, 0);
    chk("rst_mem_addr", obs_addr, 0);
    chk("rst_vid_data", obs_vdata, 0);
    chk("rst_cpu_rd_data", obs_cdata, 0);
    reset_n = 1'b1;

    access(1'b0, 1'b1, 1'b0, 13'h401, 8'h00, ack_at, acks, we_cnt);
    chk("vid_rd_ack_cycle", ack_at, 3);
    chk("vid_rd_ack_count", acks, 1);
    chk("vid_rd_we_count", we_cnt, 0);
    chk("vid_rd_data", obs_vdata, 8'h41);

    access(1'b1, 1'b0, 1'b1, 13'h010, 8'h5A, ack_at, acks, we_cnt);
    chk("cpu_wr_ack_cycle", ack_at, 2);
    chk("cpu_wr_ack_count", acks, 1);
    chk("cpu_wr_we_count", we_cnt, 1);
    chk("cpu_wr_mem", mem_a[13'h010], 8'h5A);
    chk("cpu_wr_rd_data_kept", obs_cdata, 8'h00);
    chk("vid_data_kept_over_cpu", obs_vdata, 8'h41);

    access(1'b0, 1'b1, 1'b0, 13'h010, 8'h00, ack_at, acks, we_cnt);
    chk("vid_after_wr_cycle", ack_at, 3);
    chk("vid_after_wr_data", obs_vdata, 8'h5A);

    access(1'b1, 1'b1, 1'b0, 13'h401, 8'h00, ack_at, acks, we_cnt);
    chk("cpu_rd_ack_cycle", ack_at, 3);
    chk("cpu_rd_data", obs_cdata, 8'h41);
    chk("cpu_rd_vid_kept", obs_vdata, 8'h5A);

    access(1'b1, 1'b1, 1'b1, 13'h020, 8'hC3, ack_at, acks, we_cnt);
    chk("both_strobes_mem", mem_a[13'h020], 8'hC3);
    chk("both_strobes_ack_count", acks, 1);
    chk("both_strobes_we_count", we_cnt, 1);
    chk("both_strobes_rd_data_kept", obs_cdata, 8'h41);

    // Video always requesting while a CPU read waits from the start.
    n_ev = 0; cdrop = 0;
    foreach (ev[i]) begin ev[i] = -1; ev_t[i] = 0; end
    @(negedge sys_clk);
    drive(1'b1, 13'h010, 1'b1, 1'b0, 13'h401, 8'h00);
    for (int c = 1; c <= 60 && n_ev < 6; c++) begin
      @(negedge sys_clk);
      if (c == cdrop) drive(1'b1, 13'h010, 1'b0, 1'b0, 13'h0, 8'h00);
      if (obs_vack || obs_cack) begin
        ev[n_ev] = (obs_cack && !obs_vack) ? 1 : (obs_vack && !obs_cack) ? 0 : 2;
        ev_t[n_ev] = c;
        n_ev++;
        if (obs_cack) cdrop = c + 1;
      end
    end
    @(negedge sys_clk);
    drive(1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
    repeat (8) @(negedge sys_clk);
    chk("starve_events", n_ev, 6);
    chk("starve_ev0_vid", ev[0], 0);
    chk("starve_ev1_vid", ev[1], 0);
    chk("starve_ev2_vid", ev[2], 0);
    chk("starve_ev3_vid", ev[3], 0);
    chk("starve_ev4_cpu", ev[4], 1);
    chk("starve_ev5_vid", ev[5], 0);
    chk("starve_first_ack", ev_t[0], 3);
    chk("b2b_vid_period", ev_t[1] - ev_t[0], 5);
    chk("starve_cpu_ack_cycle", ev_t[4], 23);
    chk("starve_cpu_data", obs_cdata, 8'h41);
    chk("starve_vid_data", obs_vdata, 8'h5A);

    @(negedge sys_clk);
    drive(1'b1, 13'h401, 1'b0, 1'b0, 13'h0, 8'h0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    reset_n = 1'b0;
    drive(1'b0, 13'h0, 1'b0, 1'b0, 13'h0, 8'h0);
    #1;
    chk("midrst_vid_ack", obs_vack, 0);
    chk("midrst_cpu_ack", obs_cack, 0);
    chk("midrst_mem_we", obs_we, 0);
    chk("midrst_mem_addr", obs_addr, 0);
    chk("midrst_vid_data", obs_vdata, 0);
    chk("midrst_cpu_rd_data", obs_cdata, 0);
    @(negedge sys_clk);
    chk("midrst_no_ack", obs_vack, 0);
    reset_n = 1'b1;
    access(1'b0, 1'b1, 1'b0, 13'h401, 8'h00, ack_at, acks, we_cnt);
    chk("post_rst_ack_cycle", ack_at, 3);
    chk("post_rst_ack_count", acks, 1);
    chk("post_rst_vid_data", obs_vdata, 8'h41);

    sel_b = 1'b1;
    access(1'b1, 1'b1, 1'b0, 13'h055, 8'h00, ack_at, acks, we_cnt);
    chk("lat3_cpu_ack_cycle", ack_at, 5);
    chk("lat3_cpu_data", obs_cdata, 8'h9E);
    access(1'b0, 1'b1, 1'b0, 13'h123, 8'h00, ack_at, acks, we_cnt);
    chk("lat3_vid_ack_cycle", ack_at, 5);
    chk("lat3_vid_ack_count", acks, 1);
    chk("lat3_vid_data", obs_vdata, 8'h77);
    chk("lat3_cpu_data_kept", obs_cdata, 8'h9E);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
